// File: rtl/io_pkg.sv
// Shared IO definitions: FSM state encoding and board IO address map.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_CONFIRM = 2'd1,
    DONE         = 2'd2
  } io_state_e;

  localparam logic [31:0] IO_SW_ADDR  = 32'hFFFF_FC70;
  localparam logic [31:0] IO_LED_ADDR = 32'hFFFF_FFC2;
  localparam logic [31:0] IO_SEG_ADDR = 32'hFFFF_FFF0;

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer plus stability counter for a raw button input.
// Emits a one-cycle pulse when the debounced level goes 0 -> 1.
module io_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic rise_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronized level differs from the stable level.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, counter and stable level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/io_access_ctrl.sv
// CPU memory-mapped IO sequencer: LED/segment write strobes and
// operator-confirmed switch reads.
// Optional macro IO_TIMEOUT_EN adds a confirm-wait timeout (parameter
// TIMEOUT_CYCLES exists only in that build).
//
// state        | meaning
// IDLE         | waiting for a CPU request, request fields sampled here
// WAIT_CONFIRM | switch read pending, waiting for debounced confirm press
// DONE         | one-cycle completion, req_ready and strobes/errors visible
module io_access_ctrl
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [31:0] SW_ADDR         = IO_SW_ADDR,
  parameter logic [31:0] LED_ADDR        = IO_LED_ADDR,
`ifdef IO_TIMEOUT_EN
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000,
`endif
  parameter logic [31:0] SEG_ADDR        = IO_SEG_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic [31:0] rsp_rdata,
  input  logic        confirm_btn,
  input  logic [15:0] switch_in,
  output logic        led_we,
  output logic        seg_we,
  output logic [31:0] io_wdata,
  output logic        err_unmapped,
  output logic        err_timeout
);

  io_state_e   state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        led_we_q, led_we_d;
  logic        seg_we_q, seg_we_d;
  logic        err_unmapped_q, err_unmapped_d;
  logic [31:0] io_wdata_q, io_wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [15:0] sw_sync1_q, sw_sync2_q;
  logic        confirm_rise;

`ifdef IO_TIMEOUT_EN
  logic        err_timeout_q, err_timeout_d;
  logic [31:0] tmo_q, tmo_d;
`endif

  io_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_confirm_db (
    .clk    (clk),
    .rst    (rst),
    .btn_in (confirm_btn),
    .rise_o (confirm_rise)
  );

  // Switch levels only need synchronizing; the operator confirms when they are settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= switch_in;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  // Next-state and registered-output decode for the access FSM.
  always_comb begin
    state_d        = state_q;
    req_ready_d    = 1'b0;
    led_we_d       = 1'b0;
    seg_we_d       = 1'b0;
    err_unmapped_d = 1'b0;
    io_wdata_d     = io_wdata_q;
    rsp_rdata_d    = rsp_rdata_q;
`ifdef IO_TIMEOUT_EN
    err_timeout_d  = 1'b0;
    tmo_d          = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = DONE;
          req_ready_d = 1'b1;
          rsp_rdata_d = '0;
          if (req_we && req_addr == LED_ADDR) begin
            led_we_d   = 1'b1;
            io_wdata_d = req_wdata;
          end else if (req_we && req_addr == SEG_ADDR) begin
            seg_we_d   = 1'b1;
            io_wdata_d = req_wdata;
          end else if (!req_we && req_addr == SW_ADDR) begin
            state_d     = WAIT_CONFIRM;
            req_ready_d = 1'b0;
            rsp_rdata_d = rsp_rdata_q;
`ifdef IO_TIMEOUT_EN
            tmo_d       = '0;
`endif
          end else begin
            err_unmapped_d = 1'b1;
          end
        end
      end
      WAIT_CONFIRM: begin
        if (confirm_rise) begin
          state_d     = DONE;
          req_ready_d = 1'b1;
          rsp_rdata_d = {16'b0, sw_sync2_q};
        end
`ifdef IO_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d       = DONE;
          req_ready_d   = 1'b1;
          rsp_rdata_d   = '0;
          err_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b0;
      led_we_q       <= 1'b0;
      seg_we_q       <= 1'b0;
      err_unmapped_q <= 1'b0;
      io_wdata_q     <= '0;
      rsp_rdata_q    <= '0;
`ifdef IO_TIMEOUT_EN
      err_timeout_q  <= 1'b0;
      tmo_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      led_we_q       <= led_we_d;
      seg_we_q       <= seg_we_d;
      err_unmapped_q <= err_unmapped_d;
      io_wdata_q     <= io_wdata_d;
      rsp_rdata_q    <= rsp_rdata_d;
`ifdef IO_TIMEOUT_EN
      err_timeout_q  <= err_timeout_d;
      tmo_q          <= tmo_d;
`endif
    end
  end

  assign req_ready    = req_ready_q;
  assign led_we       = led_we_q;
  assign seg_we       = seg_we_q;
  assign err_unmapped = err_unmapped_q;
  assign io_wdata     = io_wdata_q;
  assign rsp_rdata    = rsp_rdata_q;
`ifdef IO_TIMEOUT_EN
  assign err_timeout  = err_timeout_q;
`else
  assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_io_access_ctrl.sv
// Scoreboard bench for io_access_ctrl with DEBOUNCE_CYCLES=4.
module tb_io_access_ctrl;
  import io_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready;
  logic [31:0] rsp_rdata;
  logic        confirm_btn;
  logic [15:0] switch_in;
  logic        led_we, seg_we;
  logic [31:0] io_wdata;
  logic        err_unmapped, err_timeout;

  always #5 clk = ~clk;

  io_access_ctrl #(
`ifdef IO_TIMEOUT_EN
    .TIMEOUT_CYCLES (32'd20),
`endif
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_rdata   (rsp_rdata),
    .confirm_btn (confirm_btn),
    .switch_in   (switch_in),
    .led_we      (led_we),
    .seg_we      (seg_we),
    .io_wdata    (io_wdata),
    .err_unmapped(err_unmapped),
    .err_timeout (err_timeout)
  );

  typedef struct packed {
    logic        led_we;
    logic        seg_we;
    logic        err_unm;
    logic        err_tmo;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_pop;
  int   cmp_cnt  = 0;
  int   err_cnt  = 0;
  int   comp_cnt = 0;
  int   cyc      = 0;
  logic prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic l, input logic s, input logic u, input logic t,
                              input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.led_we = l; e.seg_we = s; e.err_unm = u; e.err_tmo = t; e.wdata = wd; e.rdata = rd;
    return e;
  endfunction

  // Monitor: compare every completion against the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready) begin
        comp_cnt++;
        chk("back_to_back", {31'b0, prev_ready}, 32'd0);
        chk("sb_nonempty", {31'b0, (sb_q.size() != 0)}, 32'd1);
        if (sb_q.size() != 0) begin
          e_pop = sb_q.pop_front();
          chk("led_we", {31'b0, led_we}, {31'b0, e_pop.led_we});
          chk("seg_we", {31'b0, seg_we}, {31'b0, e_pop.seg_we});
          chk("err_unmapped", {31'b0, err_unmapped}, {31'b0, e_pop.err_unm});
          chk("err_timeout", {31'b0, err_timeout}, {31'b0, e_pop.err_tmo});
          chk("io_wdata", io_wdata, e_pop.wdata);
          chk("rsp_rdata", rsp_rdata, e_pop.rdata);
        end
      end else if (led_we | seg_we | err_unmapped | err_timeout) begin
        chk("strobe_without_ready", {28'b0, led_we, seg_we, err_unmapped, err_timeout}, 32'd0);
      end
    end
    prev_ready <= req_ready;
  end

  task automatic wait_ready(input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!req_ready && lat < budget);
    if (!req_ready) lat = -1;
  endtask

  task automatic do_req(input bit gap, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input exp_t e, input int exp_lat,
                        input string name);
    int lat;
    if (gap) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    sb_q.push_back(e);
    wait_ready(50, lat);
    req_valid = 1'b0;
    chk(name, lat, exp_lat);
  endtask

  task automatic read_with_press(input int delay, input int hold, input string name);
    int press_cyc, ready_cyc, lat;
    press_cyc = 0; ready_cyc = 0;
    fork
      begin
        repeat (delay) @(negedge clk);
        press_cyc = cyc;
        confirm_btn = 1'b1;
        repeat (hold) @(negedge clk);
        confirm_btn = 1'b0;
      end
      begin
        wait_ready(80, lat);
        ready_cyc = cyc;
        req_valid = 1'b0;
        if (lat < 0) chk({name, "_timeout"}, lat, 32'd0);
      end
    join
    chk(name, ready_cyc - press_cyc, 32'd7);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [31:0] wd;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    confirm_btn = 1'b0; switch_in = 16'hBEEF;
    repeat (3) @(negedge clk);
    chk("rst_pulses", {27'b0, req_ready, led_we, seg_we, err_unmapped, err_timeout}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_wdata", io_wdata, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mapped writes: one-cycle latency
    do_req(1, 1'b1, IO_LED_ADDR, 32'h0000_A5A5, mk(1, 0, 0, 0, 32'h0000_A5A5, 0), 1, "led_lat");
    do_req(1, 1'b1, IO_SEG_ADDR, 32'h1234_5678, mk(0, 1, 0, 0, 32'h1234_5678, 0), 1, "seg_lat");
    wd = 32'h1234_5678;

    // Switch read confirmed by an 8-cycle press 10 cycles after the request
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = IO_SW_ADDR;
    sb_q.push_back(mk(0, 0, 0, 0, wd, 32'h0000_BEEF));
    read_with_press(10, 8, "press8_lat");
    chk("rdata_hold", rsp_rdata, 32'h0000_BEEF);
    chk("single_completion", comp_cnt, 32'd3);

    // 3-cycle glitch must not complete; a 6-cycle press then does
    switch_in = 16'h1357;
    repeat (3) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = IO_SW_ADDR;
    sb_q.push_back(mk(0, 0, 0, 0, wd, 32'h0000_1357));
    repeat (5) @(negedge clk);
    c0 = comp_cnt;
    confirm_btn = 1'b1;
    repeat (3) @(negedge clk);
    confirm_btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_no_cpl", comp_cnt, c0);
    read_with_press(1, 6, "press6_lat");

    // Unmapped address / wrong direction
    do_req(1, 1'b0, 32'hFFFF_0000, 32'h0, mk(0, 0, 1, 0, wd, 0), 1, "unm_read_lat");
    do_req(1, 1'b1, IO_SW_ADDR, 32'h0000_DEAD, mk(0, 0, 1, 0, wd, 0), 1, "unm_swwr_lat");
    do_req(1, 1'b0, IO_LED_ADDR, 32'h0, mk(0, 0, 1, 0, wd, 0), 1, "unm_ledrd_lat");

    // New request presented right after req_ready
    do_req(1, 1'b1, IO_LED_ADDR, 32'h0000_00FF, mk(1, 0, 0, 0, 32'h0000_00FF, 0), 1, "b2b_first_lat");
    do_req(0, 1'b1, IO_SEG_ADDR, 32'h0000_0F0F, mk(0, 1, 0, 0, 32'h0000_0F0F, 0), 2, "b2b_second_lat");

    // Reset while waiting for confirm: no completion afterwards
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = IO_SW_ADDR;
    repeat (4) @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_pulses", {27'b0, req_ready, led_we, seg_we, err_unmapped, err_timeout}, 32'd0);
    chk("midrst_wdata", io_wdata, 32'd0);
    rst = 1'b0;
    c0 = comp_cnt;
    confirm_btn = 1'b1;
    repeat (6) @(negedge clk);
    confirm_btn = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst_no_cpl", comp_cnt, c0);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    do_req(1, 1'b1, IO_LED_ADDR, 32'hCAFE_0001, mk(1, 0, 0, 0, 32'hCAFE_0001, 0), 1, "post_rst_lat");
    wd = 32'hCAFE_0001;

`ifdef IO_TIMEOUT_EN
    do_req(1, 1'b0, IO_SW_ADDR, 32'h0, mk(0, 0, 0, 1, wd, 0), 21, "timeout_lat");
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
